mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Initiator-side sequencer that drives one mac unit through a complete dot product of length vec_len.
- Accepts operand pairs on a valid/ready stream and generates the MAC's enable/set_sum/in_1/in_2 controls.
- Captures the MAC's combinational out on the final element and presents the sum on a valid/ready result port.
- Sits between the operand buffers and the MAC array in the compute datapath.

Parameters:
- IN_WIDTH, 8: operand width; must match the connected mac.
- OUT_WIDTH, 20: accumulator/result width; must equal 2*IN_WIDTH+4, matching the mac's fixed 4-bit zero pad.
- LEN_WIDTH, 10: width of vec_len and the element counter.

Ports:
- CLK  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  begin a job; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current job.
- vec_len  input  LEN_WIDTH  element count; latched on accepted start.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer accepts a pair this cycle.
- in_a  input  IN_WIDTH  operand A.
- in_b  input  IN_WIDTH  operand B.
- mac_enable  output  1  to mac enable.
- mac_set_sum  output  1  to mac set_sum.
- mac_in_1  output  IN_WIDTH  to mac in_1.
- mac_in_2  output  IN_WIDTH  to mac in_2.
- mac_out  input  OUT_WIDTH  from mac out (combinational).
- res_valid  output  1  result valid.
- res_ready  input  1  result consumer ready.
- res_data  output  OUT_WIDTH  dot-product result.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse on result handshake.

Behaviour:
- Reset:
  - state=IDLE, count=0, len_q=0, res_data=0.
  - All outputs 0.
  - The MAC's internal sum is not cleared by this block; the first element's set_sum overrides it.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=0.
  - start=1 with vec_len!=0: len_q<=vec_len, count<=0, go to ACCUM.
  - start=1 with vec_len==0: res_data<=0, go to OUTPUT.
- ACCUM:
  - in_ready=1.
  - Transfer = in_valid & in_ready.
  - mac_enable=transfer (combinational); never asserted without a transfer.
  - mac_set_sum=transfer & (count==0).
  - mac_in_1=in_a and mac_in_2=in_b, passed through combinationally.
  - Each transfer increments count.
  - On a transfer with count==len_q-1: res_data<=mac_out (the full sum, same cycle), go to OUTPUT.
  - in_valid bubbles stall with no side effects.
- OUTPUT:
  - in_ready=0, res_valid=1, res_data held stable.
  - res_ready=1: done=1 for that cycle, go to IDLE.
- Latency: res_valid rises the cycle after the last operand transfer.
- Throughput: 1 pair/cycle in ACCUM. A new start is accepted one cycle after done, not in the done cycle.
- start outside IDLE is ignored.
- abort=1 in ACCUM or OUTPUT:
  - Go to IDLE next cycle; count<=0; no done pulse.
  - In the abort cycle, in_ready=0 and mac_enable=0.
  - abort outranks a simultaneous transfer or result handshake.
  - abort in IDLE has no effect and outranks start.
- Arithmetic: the sum wraps modulo 2^OUT_WIDTH, inherited from the mac. No saturation, no overflow flag.
- rst asserted mid-job: immediate return to reset values. Any partial MAC sum is discarded by the next job's set_sum.

Test Plan:
- Basic: len=4, pairs (1,5),(2,6),(3,7),(4,8) back-to-back, res_ready=1 -> res_data=70.
  - set_sum high only on the first pair; res_valid the cycle after the 4th pair; done pulse.
- Stalls: same job with in_valid low for 2 cycles between every pair -> mac_enable low during bubbles, res_data=70.
- Backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data=70 held stable, in_ready=0, start ignored. Release -> done, IDLE.
- Wrap: len=20, all pairs (255,255) -> res_data=251924 (1300500 mod 2^20).
  - Then a len=1 (3,4) job -> 12, confirming set_sum discards the old sum.
- Zero length: start with vec_len=0 -> res_valid next cycle with res_data=0, mac_enable never asserted.
- Abort/reset: abort after 2 of 4 pairs -> IDLE, no done, a new len=2 (1,1),(1,1) job -> 2.
  - Assert rst mid-ACCUM -> all outputs 0 asynchronously; a subsequent job is correct.

Source files
------------

// File: rtl/mac_seq_if.sv
// Operand and result valid/ready streams of the dot-product sequencer.
// master = operand/result side of the datapath, slave = sequencer.
`timescale 1ns/1ps
interface mac_seq_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 20
);
  logic                 in_valid;
  logic                 in_ready;
  logic [IN_WIDTH-1:0]  in_a;
  logic [IN_WIDTH-1:0]  in_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [OUT_WIDTH-1:0] res_data;

  modport master (
    output in_valid, in_a, in_b, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_a, in_b, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/mac_seq.sv
// Sequencer that walks one external MAC through a dot product of vec_len pairs
// and returns the captured sum on a valid/ready result port.
`timescale 1ns/1ps
module mac_seq #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 20,
  parameter int LEN_WIDTH = 10
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_WIDTH-1:0] vec_len,
  mac_seq_if.slave             bus,
  output logic                 mac_enable,
  output logic                 mac_set_sum,
  output logic [IN_WIDTH-1:0]  mac_in_1,
  output logic [IN_WIDTH-1:0]  mac_in_2,
  input  logic [OUT_WIDTH-1:0] mac_out,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] len_q,   len_d;
  logic [OUT_WIDTH-1:0] res_q,   res_d;
  logic                 transfer;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        // abort in IDLE only suppresses a simultaneous start
        if (start && !abort) begin
          if (vec_len != '0) begin
            len_d   = vec_len;
            count_d = '0;
            state_d = ACCUM;
          end else begin
            res_d   = '0;
            state_d = OUTPUT;
          end
        end
      end
      ACCUM: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (transfer) begin
          count_d = count_q + LEN_WIDTH'(1);
          // mac_out already includes this pair, so it is the finished sum
          if (count_q == len_q - LEN_WIDTH'(1)) begin
            res_d   = mac_out;
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ACCUM) && !abort;
    transfer      = bus.in_valid && bus.in_ready;
    mac_enable    = transfer;
    mac_set_sum   = transfer && (count_q == '0);
    mac_in_1      = (state_q == ACCUM) ? bus.in_a : '0;
    mac_in_2      = (state_q == ACCUM) ? bus.in_b : '0;
    bus.res_valid = (state_q == OUTPUT);
    bus.res_data  = res_q;
    busy          = (state_q != IDLE);
    done          = (state_q == OUTPUT) && bus.res_ready && !abort;
  end

endmodule

// File: tb/tb_mac_seq.sv
// Bench for mac_seq: directed jobs from the test plan plus randomized jobs,
// checked every cycle against a job-level model and per job against a plain dot product.
`timescale 1ns/1ps
module tb_mac_seq;
  localparam int IW = 8;
  localparam int OW = 20;
  localparam int LW = 10;

  logic          clk = 0;
  logic          rst = 0;
  logic          start = 0;
  logic          abort = 0;
  logic [LW-1:0] vec_len = '0;
  logic          mac_enable, mac_set_sum, busy, done;
  logic [IW-1:0] mac_in_1, mac_in_2;
  logic [OW-1:0] mac_out;
  logic [OW-1:0] mac_sum = '0;

  mac_seq_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  mac_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .CLK(clk), .rst(rst), .start(start), .abort(abort), .vec_len(vec_len),
    .bus(bus), .mac_enable(mac_enable), .mac_set_sum(mac_set_sum),
    .mac_in_1(mac_in_1), .mac_in_2(mac_in_2), .mac_out(mac_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // MAC unit the sequencer drives: combinational out, sum never reset
  assign mac_out = (mac_set_sum ? '0 : mac_sum) + OW'(mac_in_1) * OW'(mac_in_2);
  always @(posedge clk) if (mac_enable) mac_sum <= mac_out;

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  int n_en = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Job-level model: elements still owed, elements taken, running sum, held result
  int            m_left = 0;
  int            m_idx = 0;
  logic          m_hold = 0;
  logic [OW-1:0] m_acc = '0;
  logic [OW-1:0] m_res = '0;
  logic [OW-1:0] nxt_acc;
  logic          e_rdy, e_en, e_set, e_busy, e_done;

  assign nxt_acc = (m_idx == 0 ? '0 : m_acc) + OW'(bus.in_a) * OW'(bus.in_b);
  assign e_rdy   = (m_left != 0) && !abort;
  assign e_en    = e_rdy && bus.in_valid;
  assign e_set   = e_en && (m_idx == 0);
  assign e_busy  = (m_left != 0) || m_hold;
  assign e_done  = m_hold && bus.res_ready && !abort;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0; m_idx <= 0; m_hold <= 0; m_acc <= '0; m_res <= '0;
    end else if (m_left != 0) begin
      if (abort) m_left <= 0;
      else if (bus.in_valid) begin
        m_acc  <= nxt_acc;
        m_idx  <= m_idx + 1;
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_res  <= nxt_acc;
          m_hold <= 1'b1;
        end
      end
    end else if (m_hold) begin
      if (abort || bus.res_ready) m_hold <= 1'b0;
    end else if (start && !abort) begin
      if (vec_len == '0) begin
        m_res  <= '0;
        m_hold <= 1'b1;
      end else begin
        m_left <= int'(vec_len);
        m_idx  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("in_ready", bus.in_ready, e_rdy);
    check("mac_enable", mac_enable, e_en);
    check("mac_set_sum", mac_set_sum, e_set);
    check("res_valid", bus.res_valid, m_hold);
    check("res_data", bus.res_data, m_res);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    if (e_en) begin
      check("mac_in_1", mac_in_1, bus.in_a);
      check("mac_in_2", mac_in_2, bus.in_b);
    end
    if (done) n_done <= n_done + 1;
    if (mac_enable) n_en <= n_en + 1;
  end

  logic [IW-1:0] pa [64];
  logic [IW-1:0] pb [64];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bub < 0 picks 0..2 random bubbles before each pair; abort_at >= 0 aborts on that pair
  task automatic job(input int len, input int bub, input int hold, input int abort_at,
                     output logic [OW-1:0] res);
    res = '0;
    bus.res_ready = 0;
    start = 1; vec_len = LW'(len);
    step();
    start = 0;
    for (int i = 0; i < len; i++) begin
      int nb;
      nb = (bub < 0) ? int'($urandom_range(0, 2)) : bub;
      for (int k = 0; k < nb; k++) begin
        bus.in_valid = 0;
        step();
      end
      bus.in_valid = 1; bus.in_a = pa[i]; bus.in_b = pb[i];
      if (i == abort_at) begin
        abort = 1;
        step();
        abort = 0; bus.in_valid = 0;
        return;
      end
      step();
    end
    bus.in_valid = 0;
    check("latency_res_valid", bus.res_valid, 1);
    for (int h = 0; h < hold; h++) begin
      start = 1;
      step();
    end
    start = 0;
    res = bus.res_data;
    bus.res_ready = 1;
    step();
    bus.res_ready = 0;
  endtask

  function automatic logic [OW-1:0] dot(input int len);
    logic [OW-1:0] s = '0;
    for (int i = 0; i < len; i++) s = s + OW'(pa[i]) * OW'(pb[i]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [OW-1:0] r;
    int d0, e0, len, ab;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 0;
    #1 rst = 1;
    step(); step();
    check("reset_busy", busy, 0);
    check("reset_res_valid", bus.res_valid, 0);
    check("reset_res_data", bus.res_data, 0);
    check("reset_in_ready", bus.in_ready, 0);
    @(negedge clk) rst = 0;
    step();

    for (int i = 0; i < 4; i++) begin pa[i] = IW'(i + 1); pb[i] = IW'(i + 5); end
    d0 = n_done;
    job(4, 0, 0, -1, r);
    check("basic_sum", r, 70);
    check("basic_done_count", n_done - d0, 1);
    job(4, 2, 0, -1, r);
    check("stall_sum", r, 70);
    job(4, 0, 5, -1, r);
    check("backpressure_sum", r, 70);
    check("backpressure_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
    job(20, 0, 0, -1, r);
    check("wrap_sum", r, 251924);
    pa[0] = 8'd3; pb[0] = 8'd4;
    job(1, 0, 0, -1, r);
    check("set_sum_discard", r, 12);

    e0 = n_en;
    job(0, 0, 0, -1, r);
    check("zero_len_sum", r, 0);
    check("zero_len_no_enable", n_en - e0, 0);

    for (int i = 0; i < 4; i++) begin pa[i] = IW'(i + 1); pb[i] = IW'(i + 5); end
    d0 = n_done;
    job(4, 0, 0, 2, r);
    check("abort_idle", busy, 0);
    check("abort_no_done", n_done - d0, 0);
    pa[0] = 1; pb[0] = 1; pa[1] = 1; pb[1] = 1;
    job(2, 0, 0, -1, r);
    check("after_abort_sum", r, 2);

    start = 1; vec_len = LW'(4);
    step();
    start = 0;
    bus.in_valid = 1; bus.in_a = 8'd9; bus.in_b = 8'd9;
    step(); step();
    #2 rst = 1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mac_enable", mac_enable, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_valid", bus.res_valid, 0);
    @(negedge clk);
    rst = 0; bus.in_valid = 0;
    step();
    pa[0] = 3; pb[0] = 5; pa[1] = 4; pb[1] = 6;
    job(2, 0, 0, -1, r);
    check("after_rst_sum", r, 39);

    for (int j = 0; j < 40; j++) begin
      len = int'($urandom_range(0, 12));
      for (int i = 0; i < len; i++) begin
        pa[i] = IW'($urandom);
        pb[i] = IW'($urandom);
      end
      ab = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      job(len, -1, int'($urandom_range(0, 3)), ab, r);
      if (ab < 0) check("random_sum", r, dot(len));
      else check("random_abort_idle", busy, 0);
    end

    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
